// File: rtl/func_unit_rr_scheduler.sv
// Round-robin scheduler sharing one 10-op func unit: 1+L cycles accept-to-valid (L=LAT_MUL/LAT_DIV/1), 1 for illegal ops.
// Grants only in IDLE; result held until resp_ready. FU_SCHED_DIVZERO_EN adds resp_divzero and a div-by-zero bypass.
module func_unit_rr_scheduler #(
  parameter int SIZE    = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 8
) (
  input  logic                    CGRA_Clock,
  input  logic                    CGRA_Reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*SIZE-1:0] req_a,
  input  logic [NUM_REQ*SIZE-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]    req_op,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [SIZE-1:0]         resp_data,
  output logic [SIZE-1:0]         fu_a,
  output logic [SIZE-1:0]         fu_b,
  output logic [3:0]              fu_select,
  input  logic [SIZE-1:0]         fu_out
`ifdef FU_SCHED_DIVZERO_EN
  ,
  output logic                    resp_divzero
`endif
);

  localparam int LAT_MAX = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(LAT_MUL - 1);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(LAT_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [SIZE-1:0]   r_fu_a;
  logic [SIZE-1:0]   r_fu_b;
  logic [3:0]        r_fu_select;
  logic [SIZE-1:0]   r_resp_data;
  logic [ID_W-1:0]   r_resp_id;

  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_idx;
  logic [SIZE-1:0]   w_a;
  logic [SIZE-1:0]   w_b;
  logic [3:0]        w_op;
  logic              w_illegal;
  logic              w_divzero;
  logic              w_skip;
  logic [CNT_W-1:0]  w_cnt_init;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_a       = req_a[w_winner*SIZE +: SIZE];
  assign w_b       = req_b[w_winner*SIZE +: SIZE];
  assign w_op      = req_op[w_winner*4 +: 4];
  assign w_illegal = w_op[3] & (w_op[2] | w_op[1]);
`ifdef FU_SCHED_DIVZERO_EN
  assign w_divzero = (w_op == 4'd3) && (w_b == '0);
`else
  assign w_divzero = 1'b0;
`endif
  assign w_skip    = w_illegal | w_divzero;

  always_comb begin
    w_cnt_init = '0;
    if (w_op == 4'd2)      w_cnt_init = CNT_MUL;
    else if (w_op == 4'd3) w_cnt_init = CNT_DIV;
  end

  assign req_ready  = (r_state == S_IDLE && w_found) ? (NUM_REQ'(1) << w_winner) : '0;
  assign resp_valid = (r_state == S_RESP);
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign fu_a       = r_fu_a;
  assign fu_b       = r_fu_b;
  assign fu_select  = r_fu_select;

  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = w_skip ? S_RESP : S_EXEC;
      S_EXEC:  if (r_cnt == '0) w_state_nxt = S_RESP;
      S_RESP:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) begin
      r_rr_ptr    <= ID_W'(NUM_REQ - 1);
      r_cnt       <= '0;
      r_fu_a      <= '0;
      r_fu_b      <= '0;
      r_fu_select <= '0;
      r_resp_data <= '0;
      r_resp_id   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_fu_a      <= w_a;
            r_fu_b      <= w_b;
            r_fu_select <= w_illegal ? 4'd0 : w_op;
            r_resp_id   <= w_winner;
            r_rr_ptr    <= w_winner;
            r_cnt       <= w_cnt_init;
            if (w_illegal)      r_resp_data <= '0;
            else if (w_divzero) r_resp_data <= '1;
          end
        end
        S_EXEC: begin
          // The unit's output is only trusted once the multicycle window has elapsed.
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
          else             r_resp_data <= fu_out;
        end
        default: ;
      endcase
    end
  end

`ifdef FU_SCHED_DIVZERO_EN
  logic r_divzero;
  assign resp_divzero = r_divzero;

  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset)                         r_divzero <= 1'b0;
    else if (r_state == S_IDLE && w_found)  r_divzero <= w_divzero;
    else if (r_state == S_RESP && resp_ready) r_divzero <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_func_unit_rr_scheduler.sv
// Scoreboard bench for func_unit_rr_scheduler with a behavioural model of the shared func unit.
module tb_func_unit_rr_scheduler;
  localparam int SIZE    = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT_MUL = 3;
  localparam int LAT_DIV = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*SIZE-1:0] req_a;
  logic [NUM_REQ*SIZE-1:0] req_b;
  logic [NUM_REQ*4-1:0]    req_op;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [ID_W-1:0]         resp_id;
  logic [SIZE-1:0]         resp_data;
  logic [SIZE-1:0]         fu_a;
  logic [SIZE-1:0]         fu_b;
  logic [3:0]              fu_select;
  logic [SIZE-1:0]         fu_out;
`ifdef FU_SCHED_DIVZERO_EN
  logic                    resp_divzero;
`endif

  always #5 clk = ~clk;

  func_unit_rr_scheduler #(
    .SIZE(SIZE), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)
  ) dut (
    .CGRA_Clock(clk),
    .CGRA_Reset(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .req_op(req_op),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id(resp_id),
    .resp_data(resp_data),
    .fu_a(fu_a),
    .fu_b(fu_b),
    .fu_select(fu_select),
    .fu_out(fu_out)
`ifdef FU_SCHED_DIVZERO_EN
    ,
    .resp_divzero(resp_divzero)
`endif
  );

  always_comb begin
    case (fu_select)
      4'd0:    fu_out = fu_a + fu_b;
      4'd1:    fu_out = fu_a - fu_b;
      4'd2:    fu_out = fu_a * fu_b;
      4'd3:    fu_out = (fu_b == '0) ? '0 : fu_a / fu_b;
      4'd4:    fu_out = fu_a & fu_b;
      4'd5:    fu_out = fu_a | fu_b;
      4'd6:    fu_out = fu_a ^ fu_b;
      4'd7:    fu_out = fu_a << fu_b[4:0];
      4'd8:    fu_out = $signed(fu_a) >>> fu_b[4:0];
      4'd9:    fu_out = fu_a >> fu_b[4:0];
      default: fu_out = '0;
    endcase
  end

  typedef struct packed {
    logic            dz;
    logic [ID_W-1:0] id;
    logic [SIZE-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic [SIZE-1:0] d, input logic dz);
    exp_t e;
    e.dz   = dz;
    e.id   = ID_W'(id);
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: grant exclusivity every cycle, response contents at each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("grant_excl", {63'd0, ($countones(req_ready) <= 1) && !((|req_ready) && resp_valid)}, 64'd1);
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: id %0d data 0x%0h with nothing expected", resp_id, resp_data);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_id", resp_id, mon_e.id);
          chk("resp_data", resp_data, mon_e.data);
`ifdef FU_SCHED_DIVZERO_EN
          chk("resp_divzero", resp_divzero, mon_e.dz);
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_a[i*SIZE +: SIZE] = a;
    req_b[i*SIZE +: SIZE] = b;
    req_op[i*4 +: 4]      = op;
    req_valid[i]          = 1'b1;
  endtask

  task automatic wait_grant(output int id);
    id = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int j = 0; j < NUM_REQ; j++) if (req_ready[j]) id = j;
        break;
      end
    end
    if (id < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: no req_ready within 60 cycles");
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: no resp_valid within 60 cycles");
    end
  endtask

  // Issue one request, check grant and accept-to-valid latency; returns at the first valid cycle.
  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [31:0] exp_d, input int exp_lat, input logic dz);
    int g;
    int n;
    set_req(i, a, b, op);
    wait_grant(g);
    chk("grant_id", g, i);
    chk("grant_onehot", req_ready, 64'd1 << i);
    push_exp(i, exp_d, dz);
    tick();
    req_valid[i] = 1'b0;
    wait_valid(n);
    chk("latency", n, exp_lat);
  endtask

  task automatic drain();
    for (int c = 0; c < 60; c++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("sb_empty", sb.size(), 0);
    tick();
  endtask

  task automatic check_zero_outputs(input string nm);
    chk({nm, "_valid"}, resp_valid, 0);
    chk({nm, "_ready"}, req_ready, 0);
    chk({nm, "_id"}, resp_id, 0);
    chk({nm, "_data"}, resp_data, 0);
    chk({nm, "_fu_a"}, fu_a, 0);
    chk({nm, "_fu_b"}, fu_b, 0);
    chk({nm, "_fu_sel"}, fu_select, 0);
`ifdef FU_SCHED_DIVZERO_EN
    chk({nm, "_divzero"}, resp_divzero, 0);
`endif
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int n;
    int saw;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [31:0] t2_dat [4] = '{32'd19, 32'd28, 32'd37, 32'd46};

    req_a = '0;
    req_b = '0;
    req_op = '0;
    do_reset();

    // T1: add from requester 0
    send(0, 32'd5, 32'd3, 4'd0, 32'd8, 2, 1'b0);
    tick();

    // T2: all requesters busy, rotation from a fresh pointer
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(20 + i*10), 32'(i + 1), 4'd1);
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk("rr_order", g, order[k]);
      if (g >= 0) push_exp(g, t2_dat[g], 1'b0);
      tick();
    end
    req_valid = '0;
    drain();

    // T3: multiply; a late requester must wait for the handshake
    set_req(1, 32'd7, 32'd6, 4'd2);
    wait_grant(g);
    chk("t3_grant", g, 1);
    push_exp(1, 32'd42, 1'b0);
    resp_ready = 1'b0;
    tick();
    req_valid[1] = 1'b0;
    set_req(2, 32'd9, 32'd4, 4'd5);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
      chk("t3_no_grant_exec", req_ready, 0);
    end
    chk("t3_mul_lat", n, LAT_MUL + 1);
    repeat (2) begin
      @(negedge clk);
      chk("t3_hold_ready", req_ready, 0);
      chk("t3_hold_data", resp_data, 32'd42);
    end
    tick();
    resp_ready = 1'b1;
    @(negedge clk);
    chk("t3_hs_ready", req_ready, 0);
    @(negedge clk);
    chk("t3_grant2", req_ready, 4'b0100);
    push_exp(2, 32'd13, 1'b0);
    tick();
    req_valid[2] = 1'b0;
    wait_valid(n);
    chk("t3_or_lat", n, 2);
    tick();

    // T4: divide with consumer stalled for five cycles
    resp_ready = 1'b0;
    send(2, 32'd100, 32'd7, 4'd3, 32'd14, LAT_DIV + 1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("t4_valid_held", resp_valid, 1);
      chk("t4_data_stable", resp_data, 32'd14);
      chk("t4_id_stable", resp_id, 2);
      chk("t4_fu_sel_hold", fu_select, 4'd3);
    end
    tick();
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_idle_after_hs", resp_valid, 0);
    tick();

    // T5: illegal opcode, then reset in the middle of a divide
    send(3, 32'd1, 32'd2, 4'd12, 32'd0, 1, 1'b0);
    chk("t5_fu_sel_zero", fu_select, 0);
    tick();
    set_req(2, 32'd50, 32'd5, 4'd3);
    wait_grant(g);
    chk("t5_div_grant", g, 2);
    tick();
    req_valid[2] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("midrst");
    tick();
    rst = 1'b0;
    saw = 0;
    repeat (15) begin
      @(negedge clk);
      if (resp_valid) saw = 1;
    end
    chk("no_resp_after_reset", saw, 0);
    tick();
    set_req(0, 32'd1, 32'd1, 4'd0);
    set_req(3, 32'd3, 32'd4, 4'd0);
    wait_grant(g);
    chk("post_rst_first", g, 0);
    push_exp(0, 32'd2, 1'b0);
    tick();
    req_valid[0] = 1'b0;
    wait_grant(g);
    chk("post_rst_second", g, 3);
    push_exp(3, 32'd7, 1'b0);
    tick();
    req_valid[3] = 1'b0;
    drain();

`ifdef FU_SCHED_DIVZERO_EN
    // T6: divide by zero bypass
    send(0, 32'd9, 32'd0, 4'd3, 32'hFFFF_FFFF, 1, 1'b1);
    tick();
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
